// File: rtl/shifter.sv
// ----------------------------------------------------------------------------
// shifter: 32-bit registered barrel shifter for the miniRISC datapath.
//
// Shifts operand `a` by ShiftAmntSHIFTER using a logarithmic shifter. Stage k
// shifts by 2^k when amount bit k is set. The result is registered and has
// 1-cycle latency. The registered result is forced to zero when the enable is
// low, so that it can be OR-merged with the outputs of other units on the
// writeback path.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous, active-high reset (overrides enable)
//   a                   operand to shift
//   ShiftTypeSHIFTER    00=SLL, 01=SRL, 10=SRA, 11=ROR
//   ShiftAmntSHIFTER    unsigned shift amount, 0..WIDTH-1
//   ShifterEnblSHIFTER  1 = capture the shift result at this edge
//   SHIFTERout          registered result (0 when disabled or in reset)
// ----------------------------------------------------------------------------
module shifter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [1:0]         ShiftTypeSHIFTER,
    input  logic [SHAMT_W-1:0] ShiftAmntSHIFTER,
    input  logic               ShifterEnblSHIFTER,
    output logic [WIDTH-1:0]   SHIFTERout
);

    typedef enum logic [1:0] {
        ShSll = 2'b00,
        ShSrl = 2'b01,
        ShSra = 2'b10,
        ShRor = 2'b11
    } shift_type_e;

    shift_type_e shift_type;
    logic        sign_bit;

    assign shift_type = shift_type_e'(ShiftTypeSHIFTER);
    // SRA fill comes from the original operand's MSB at every stage.
    assign sign_bit   = a[WIDTH-1];

    // stage[0] is the operand; stage[SHAMT_W] is the fully shifted value.
    logic [SHAMT_W:0][WIDTH-1:0] stage;

    assign stage[0] = a;

    for (genvar k = 0; k < int'(SHAMT_W); k++) begin : g_stage
        localparam int unsigned Sh = 1 << k;

        logic [WIDTH-1:0] shifted;

        always_comb begin
            shifted = stage[k];
            unique case (shift_type)
                ShSll: shifted = {stage[k][WIDTH-Sh-1:0], {Sh{1'b0}}};
                ShSrl: shifted = {{Sh{1'b0}}, stage[k][WIDTH-1:Sh]};
                ShSra: shifted = {{Sh{sign_bit}}, stage[k][WIDTH-1:Sh]};
                ShRor: shifted = {stage[k][Sh-1:0], stage[k][WIDTH-1:Sh]};
                default: shifted = stage[k];
            endcase
        end

        assign stage[k+1] = ShiftAmntSHIFTER[k] ? shifted : stage[k];
    end

    logic [WIDTH-1:0] shifter_out_d;
    logic [WIDTH-1:0] shifter_out_q;

    // Zero when disabled: the result is not held.
    always_comb begin
        shifter_out_d = '0;
        if (ShifterEnblSHIFTER) begin
            shifter_out_d = stage[SHAMT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shifter_out_q <= '0;
        end else begin
            shifter_out_q <= shifter_out_d;
        end
    end

    assign SHIFTERout = shifter_out_q;

endmodule

// File: tb/tb_shifter.sv
// ----------------------------------------------------------------------------
// tb_shifter: self-checking bench for shifter.
// Directed table of vectors with hand-derived expected results, followed by
// randomized vectors checked against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_shifter;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [1:0]  typ;
    logic [4:0]  amt;
    logic        en;
    logic [31:0] out;

    int vectors;
    int miscompares;

    shifter #(
        .WIDTH  (32),
        .SHAMT_W(5)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .a                 (a),
        .ShiftTypeSHIFTER  (typ),
        .ShiftAmntSHIFTER  (amt),
        .ShifterEnblSHIFTER(en),
        .SHIFTERout        (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        en;
        logic [31:0] a;
        logic [1:0]  typ;
        logic [4:0]  amt;
        logic [31:0] exp;
    } vec_t;

    // Reference model straight from the shift definitions.
    function automatic logic [31:0] ref_shift(input logic [31:0] op, input logic [1:0] t,
                                              input logic [4:0] sh);
        logic [63:0] dbl;
        case (t)
            2'b00:   return op << sh;
            2'b01:   return op >> sh;
            2'b10:   return 32'($signed(op) >>> sh);
            default: begin
                dbl = {op, op} >> sh;
                return dbl[31:0];
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, expected %08h", name, got, exp);
        end
    endtask

    // Drive one vector, let one edge pass, compare shortly after the edge.
    task automatic apply(input string name, input logic r, input logic e, input logic [31:0] op,
                         input logic [1:0] t, input logic [4:0] sh, input logic [31:0] exp);
        rst = r;
        en  = e;
        a   = op;
        typ = t;
        amt = sh;
        @(posedge clk);
        #1;
        check(name, out, exp);
    endtask

    vec_t tbl[$];

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        en  = 1'b0;
        a   = '0;
        typ = '0;
        amt = '0;

        tbl = '{
            '{"reset0_en",     1'b1, 1'b1, 32'hFFFF_FFFF, 2'b10, 5'd3,  32'h0000_0000},
            '{"reset1_en",     1'b1, 1'b1, 32'hFFFF_FFFF, 2'b00, 5'd0,  32'h0000_0000},
            '{"sll_disabled",  1'b0, 1'b0, 32'd11,        2'b00, 5'd2,  32'h0000_0000},
            '{"sll_11_by_2",   1'b0, 1'b1, 32'd11,        2'b00, 5'd2,  32'd44},
            '{"srl_by_4",      1'b0, 1'b1, 32'h8000_0010, 2'b01, 5'd4,  32'h0800_0001},
            '{"sra_by_4",      1'b0, 1'b1, 32'h8000_0010, 2'b10, 5'd4,  32'hF800_0001},
            '{"ror_by_4",      1'b0, 1'b1, 32'h8000_0010, 2'b11, 5'd4,  32'h0800_0001},
            '{"ror_1_by_1",    1'b0, 1'b1, 32'h0000_0001, 2'b11, 5'd1,  32'h8000_0000},
            '{"sll_1_by_31",   1'b0, 1'b1, 32'h0000_0001, 2'b00, 5'd31, 32'h8000_0000},
            '{"sll_max",       1'b0, 1'b1, 32'h8000_0001, 2'b00, 5'd31, 32'h8000_0000},
            '{"srl_max",       1'b0, 1'b1, 32'h8000_0001, 2'b01, 5'd31, 32'h0000_0001},
            '{"sra_max",       1'b0, 1'b1, 32'h8000_0001, 2'b10, 5'd31, 32'hFFFF_FFFF},
            '{"ror_max",       1'b0, 1'b1, 32'h8000_0001, 2'b11, 5'd31, 32'h0000_0003},
            '{"sll_zero_amt",  1'b0, 1'b1, 32'hDEAD_BEEF, 2'b00, 5'd0,  32'hDEAD_BEEF},
            '{"srl_zero_amt",  1'b0, 1'b1, 32'hDEAD_BEEF, 2'b01, 5'd0,  32'hDEAD_BEEF},
            '{"sra_zero_amt",  1'b0, 1'b1, 32'hDEAD_BEEF, 2'b10, 5'd0,  32'hDEAD_BEEF},
            '{"ror_zero_amt",  1'b0, 1'b1, 32'hDEAD_BEEF, 2'b11, 5'd0,  32'hDEAD_BEEF},
            '{"sra_positive",  1'b0, 1'b1, 32'h7000_0000, 2'b10, 5'd4,  32'h0700_0000},
            '{"sra_all_ones",  1'b0, 1'b1, 32'hFFFF_FFFF, 2'b10, 5'd13, 32'hFFFF_FFFF},
            '{"disable_after", 1'b0, 1'b0, 32'hFFFF_FFFF, 2'b10, 5'd13, 32'h0000_0000},
            '{"sll_again",     1'b0, 1'b1, 32'h0000_00F0, 2'b00, 5'd8,  32'h0000_F000},
            '{"reset_mid_op",  1'b1, 1'b1, 32'h0000_00F0, 2'b00, 5'd8,  32'h0000_0000},
            '{"after_reset",   1'b0, 1'b1, 32'h1234_5678, 2'b11, 5'd16, 32'h5678_1234}
        };

        // Vectors are applied back-to-back: one new set of inputs every cycle.
        @(negedge clk);
        foreach (tbl[i]) begin
            apply(tbl[i].name, tbl[i].rst, tbl[i].en, tbl[i].a, tbl[i].typ, tbl[i].amt,
                  tbl[i].exp);
        end

        // Back-to-back randomized burst, then drop enable.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] op;
            logic [1:0]  t;
            logic [4:0]  sh;
            logic        e;
            logic        r;
            op = $urandom;
            t  = 2'($urandom_range(0, 3));
            case (i % 8)
                0:       sh = 5'd0;
                1:       sh = 5'd31;
                default: sh = 5'($urandom_range(0, 31));
            endcase
            if (i % 16 == 5) op = 32'hFFFF_FFFF;
            e = ($urandom_range(0, 9) != 0);
            r = ($urandom_range(0, 49) == 0);
            apply("random", r, e, op, t, sh, (r || !e) ? 32'h0 : ref_shift(op, t, sh));
        end
        apply("final_disable", 1'b0, 1'b0, 32'hA5A5_A5A5, 2'b11, 5'd7, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
